// File: rtl/unidade_entrada_dados_pkg.sv
// Shared definitions for the IN-instruction input unit: FSM encoding and
// datapath width.
package unidade_entrada_dados_pkg;

  localparam int LARGURA_DADOS = 32;

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    ESPERA_PRESS = 2'd1,
    ESPERA_SOLTA = 2'd2,
    PRONTO       = 2'd3
  } estado_t;

  // Counter width able to hold CICLOS_DEBOUNCE-1.
  function automatic int largura_contador(input int ciclos);
    return (ciclos <= 2) ? 1 : $clog2(ciclos);
  endfunction

endpackage

// File: rtl/unidade_entrada_dados_if.sv
// Board/UC side bus of the input unit: IN request, switches, button, captured
// data, stall and operator indicator.
interface unidade_entrada_dados_if #(
  parameter int LARGURA_CHAVES = 16
);
  import unidade_entrada_dados_pkg::*;

  logic                      ctrl_entrada;
  logic [LARGURA_CHAVES-1:0] chaves;
  logic                      botao;
  logic [LARGURA_DADOS-1:0]  entrada_dados;
  logic                      pausa;
  logic                      aguardando;

  modport master (
    output ctrl_entrada,
    output chaves,
    output botao,
    input  entrada_dados,
    input  pausa,
    input  aguardando
  );

  modport slave (
    input  ctrl_entrada,
    input  chaves,
    input  botao,
    output entrada_dados,
    output pausa,
    output aguardando
  );

endinterface

// File: rtl/unidade_entrada_dados_debounce_botao.sv
// Two-flop synchronizer plus stability counter for a raw board button;
// produces the debounced level and a one-cycle rising-edge pulse.
module debounce_botao
  import unidade_entrada_dados_pkg::*;
#(
  parameter int CICLOS_DEBOUNCE = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic botao_estavel,
  output logic botao_sobe
);

  localparam int                     LARGURA_CNT = largura_contador(CICLOS_DEBOUNCE);
  localparam logic [LARGURA_CNT-1:0] LIMITE      = LARGURA_CNT'(CICLOS_DEBOUNCE - 1);

  logic                   sinc_p0;
  logic                   sinc_p1;
  logic [LARGURA_CNT-1:0] contador;
  logic                   aceita;

  // Accept on the CICLOS_DEBOUNCE-th consecutive cycle of disagreement.
  assign aceita = (sinc_p1 != botao_estavel) && (contador == LIMITE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_p0       <= 1'b0;
      sinc_p1       <= 1'b0;
      contador      <= '0;
      botao_estavel <= 1'b0;
      botao_sobe    <= 1'b0;
    end else begin
      // Synchronizer stages p0 -> p1
      sinc_p0 <= botao;
      sinc_p1 <= sinc_p0;

      if ((sinc_p1 == botao_estavel) || aceita) begin
        contador <= '0;
      end else begin
        contador <= contador + 1'b1;
      end

      if (aceita) begin
        botao_estavel <= sinc_p1;
      end

      // Registered alongside the level so the pulse covers its first high cycle.
      botao_sobe <= aceita && sinc_p1;
    end
  end

endmodule

// File: rtl/unidade_entrada_dados.sv
// Input unit for IN instructions: stalls the CPU until the operator presses
// and releases the confirm button, then presents the zero-extended switches.
module unidade_entrada_dados
  import unidade_entrada_dados_pkg::*;
#(
  parameter int LARGURA_CHAVES  = 16,
  parameter int CICLOS_DEBOUNCE = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_entrada_dados_if.slave  barramento
);

  estado_t                   estado;
  estado_t                   proximo;
  logic                      captura;
  logic                      pausa;
  logic                      aguardando;
  logic                      botao_estavel;
  logic                      botao_sobe;
  logic [LARGURA_CHAVES-1:0] chaves_amostra;
  logic [LARGURA_DADOS-1:0]  dado;

  assign chaves_amostra = barramento.chaves;

  debounce_botao #(
    .CICLOS_DEBOUNCE (CICLOS_DEBOUNCE)
  ) u_debounce (
    .clock         (clock),
    .reset         (reset),
    .botao         (barramento.botao),
    .botao_estavel (botao_estavel),
    .botao_sobe    (botao_sobe)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Unsigned cast zero-extends the switches to the datapath width.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dado <= '0;
    end else if (captura) begin
      dado <= LARGURA_DADOS'(chaves_amostra);
    end
  end

  always_comb begin
    proximo    = estado;
    captura    = 1'b0;
    pausa      = 1'b0;
    aguardando = 1'b0;
    unique case (estado)
      OCIOSO: begin
        // Stall in the decode cycle itself so the PC never moves past the IN.
        pausa = barramento.ctrl_entrada;
        if (barramento.ctrl_entrada) begin
          proximo = ESPERA_PRESS;
        end
      end
      ESPERA_PRESS: begin
        pausa      = 1'b1;
        aguardando = 1'b1;
        if (!barramento.ctrl_entrada) begin
          proximo = OCIOSO;
        end else if (botao_sobe) begin
          captura = 1'b1;
          proximo = ESPERA_SOLTA;
        end
      end
      ESPERA_SOLTA: begin
        pausa = 1'b1;
        if (!barramento.ctrl_entrada) begin
          proximo = OCIOSO;
        end else if (!botao_estavel) begin
          proximo = PRONTO;
        end
      end
      PRONTO: begin
        proximo = OCIOSO;
      end
      default: begin
        proximo = OCIOSO;
      end
    endcase
  end

  assign barramento.entrada_dados = dado;
  assign barramento.pausa         = pausa;
  assign barramento.aguardando    = aguardando;

endmodule

// File: tb/tb_unidade_entrada_dados.sv
// Bench for unidade_entrada_dados: directed scenarios plus random button and
// IN traffic, all compared cycle by cycle against a behavioural model.
module tb_unidade_entrada_dados;
  import unidade_entrada_dados_pkg::*;

  localparam int LC = 16;
  localparam int CD = 4;

  logic clock = 1'b0;
  logic reset;

  unidade_entrada_dados_if #(.LARGURA_CHAVES(LC)) barramento ();

  unidade_entrada_dados #(
    .LARGURA_CHAVES  (LC),
    .CICLOS_DEBOUNCE (CD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .barramento (barramento)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obtido=%h esperado=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the button level as the operator's debounced view, and
  // the IN transaction as "waiting / pressed / finishing" flags.
  bit          amostras[$];
  int          corrida;
  bit          m_est, m_est_ant;
  bit          ocupado, pressionado, finalizando;
  logic [31:0] m_dado;
  int          conclusoes;
  logic [31:0] dado_concluido;
  bit          encadear;
  logic        ctrl_prox;

  task automatic modelo_reset();
    amostras    = {1'b0, 1'b0};
    corrida     = 0;
    m_est       = 1'b0;
    m_est_ant   = 1'b0;
    ocupado     = 1'b0;
    pressionado = 1'b0;
    finalizando = 1'b0;
    m_dado      = 32'h0;
  endtask

  function automatic bit exp_pausa();
    return ocupado || (!finalizando && barramento.ctrl_entrada);
  endfunction

  function automatic bit exp_aguardando();
    return ocupado && !pressionado;
  endfunction

  task automatic modelo_borda();
    bit sobe, sinc;
    sobe = m_est && !m_est_ant;
    sinc = amostras[amostras.size() - 2];
    if (finalizando) begin
      finalizando = 1'b0;
    end else if (!ocupado) begin
      if (barramento.ctrl_entrada) begin
        ocupado     = 1'b1;
        pressionado = 1'b0;
      end
    end else if (!barramento.ctrl_entrada) begin
      ocupado = 1'b0;
    end else if (!pressionado) begin
      if (sobe) begin
        m_dado      = {16'h0, barramento.chaves};
        pressionado = 1'b1;
      end
    end else if (!m_est) begin
      ocupado     = 1'b0;
      finalizando = 1'b1;
    end
    // The debounced level follows the synced button after CD disagreeing edges.
    m_est_ant = m_est;
    if (sinc != m_est) begin
      corrida++;
      if (corrida == CD) begin
        m_est   = sinc;
        corrida = 0;
      end
    end else begin
      corrida = 0;
    end
    amostras.push_back(barramento.botao);
    if (amostras.size() > 4) void'(amostras.pop_front());
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic ciclo();
    #1;
    confere("pausa", barramento.pausa, exp_pausa());
    confere("aguardando", barramento.aguardando, exp_aguardando());
    confere("entrada_dados", barramento.entrada_dados, m_dado);
    if (barramento.ctrl_entrada && !exp_pausa()) begin
      conclusoes++;
      dado_concluido = barramento.entrada_dados;
      ctrl_prox      = encadear;
    end else begin
      ctrl_prox = barramento.ctrl_entrada;
    end
    @(posedge clock);
    modelo_borda();
    @(negedge clock);
    barramento.ctrl_entrada = ctrl_prox;
  endtask

  task automatic espera(input int n);
    for (int i = 0; i < n; i++) ciclo();
  endtask

  task automatic pressiona(input int n_alto, input int n_baixo);
    barramento.botao = 1'b1;
    espera(n_alto);
    barramento.botao = 1'b0;
    espera(n_baixo);
  endtask

  task automatic reset_assincrono();
    #2;
    barramento.ctrl_entrada = 1'b0;
    reset = 1'b0;
    #1;
    confere("rst_entrada_dados", barramento.entrada_dados, 32'h0);
    confere("rst_pausa", barramento.pausa, 1'b0);
    confere("rst_aguardando", barramento.aguardando, 1'b0);
    modelo_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int base;
    int segura;
    reset                   = 1'b0;
    barramento.ctrl_entrada = 1'b0;
    barramento.botao        = 1'b0;
    barramento.chaves       = 16'hFFFF;
    modelo_reset();
    conclusoes     = 0;
    dado_concluido = 32'h0;
    encadear       = 1'b0;

    @(negedge clock);
    #1;
    confere("ini_entrada_dados", barramento.entrada_dados, 32'h0);
    confere("ini_pausa", barramento.pausa, 1'b0);
    confere("ini_aguardando", barramento.aguardando, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    espera(3);

    // Basic IN
    base = conclusoes;
    barramento.chaves       = 16'hBEEF;
    barramento.ctrl_entrada = 1'b1;
    #1;
    confere("basico_pausa_imediata", barramento.pausa, 1'b1);
    ciclo();
    confere("basico_aguardando", barramento.aguardando, 1'b1);
    espera(2);
    pressiona(10, 12);
    confere("basico_conclusoes", conclusoes, base + 1);
    confere("basico_dado", dado_concluido, 32'h0000BEEF);

    // Reset mid-simulation with all switches up
    barramento.chaves = 16'hFFFF;
    reset_assincrono();
    espera(2);

    // Bouncing button
    base = conclusoes;
    barramento.chaves       = 16'hA5A5;
    barramento.ctrl_entrada = 1'b1;
    for (int i = 0; i < 10; i++) begin
      barramento.botao = ~barramento.botao;
      espera(2);
    end
    confere("salto_aguardando", barramento.aguardando, 1'b1);
    pressiona(10, 12);
    confere("salto_conclusoes", conclusoes, base + 1);
    confere("salto_dado", dado_concluido, 32'h0000A5A5);

    // Button already held when the IN arrives
    base = conclusoes;
    barramento.botao = 1'b1;
    espera(10);
    barramento.chaves       = 16'h0001;
    barramento.ctrl_entrada = 1'b1;
    espera(10);
    confere("segurado_sem_captura", barramento.aguardando, 1'b1);
    barramento.botao = 1'b0;
    espera(10);
    barramento.chaves = 16'h0002;
    pressiona(10, 12);
    confere("segurado_conclusoes", conclusoes, base + 1);
    confere("segurado_dado", dado_concluido, 32'h00000002);

    // Back-to-back IN
    base = conclusoes;
    encadear                = 1'b1;
    barramento.chaves       = 16'h1234;
    barramento.ctrl_entrada = 1'b1;
    pressiona(10, 12);
    confere("seguidas_dado1", dado_concluido, 32'h00001234);
    encadear          = 1'b0;
    barramento.chaves = 16'h5678;
    pressiona(10, 12);
    confere("seguidas_conclusoes", conclusoes, base + 2);
    confere("seguidas_dado2", dado_concluido, 32'h00005678);

    // Flush while waiting for the press
    barramento.chaves       = 16'h7777;
    barramento.ctrl_entrada = 1'b1;
    espera(3);
    barramento.ctrl_entrada = 1'b0;
    espera(1);
    confere("flush_aguardando", barramento.aguardando, 1'b0);
    confere("flush_dado", barramento.entrada_dados, 32'h00005678);

    // Reset while waiting for the release
    barramento.chaves       = 16'h4242;
    barramento.ctrl_entrada = 1'b1;
    barramento.botao        = 1'b1;
    espera(9);
    confere("solta_dado", barramento.entrada_dados, 32'h00004242);
    confere("solta_pausa", barramento.pausa, 1'b1);
    reset_assincrono();
    barramento.botao = 1'b0;
    espera(2);

    // Random traffic
    segura = 0;
    for (int i = 0; i < 600; i++) begin
      if (segura == 0) begin
        barramento.botao = ~barramento.botao;
        segura = $urandom_range(1, 9);
      end
      segura--;
      barramento.chaves = 16'($urandom);
      if (!barramento.ctrl_entrada && ($urandom_range(0, 3) == 0))
        barramento.ctrl_entrada = 1'b1;
      else if (barramento.ctrl_entrada && ($urandom_range(0, 59) == 0))
        barramento.ctrl_entrada = 1'b0;
      if (i == 300) reset_assincrono();
      ciclo();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
